ws_uart_tx: RTL and testbench
=============================

Name: ws_uart_tx

Overview:
Byte-serial UART transmitter for the Whitespace CPU's output path, the transmit-side counterpart of the uart_rx program/input channel. The output-char command pushes each byte into a small FIFO through a valid/ready handshake. A transmit FSM drains the FIFO onto the top-level uart_tx pin as 8N1 frames, LSB first. The CPU never stalls on bit timing, only on FIFO full.

Parameters:
CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); legal range is 2 or more.
FIFO_DEPTH, 16, FIFO entries; must be a power of two, 2 or more.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  CPU offers in_data this cycle.
in_data  input  8  character to transmit.
in_ready  output  1  FIFO can accept; equals !full.
uart_tx  output  1  serial line, idle high.
busy  output  1  high while the FIFO is non-empty or a frame is in flight.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a posedge):
  - uart_tx=1, busy=0, fifo_count=0, in_ready=1.
  - FSM goes to IDLE; baud counter and bit index go to 0; FIFO pointers go to 0.
  - Reset mid-frame aborts the frame. The line returns high on the next cycle and no partial byte resumes.
- Handshake:
  - A push occurs on a posedge where in_valid and in_ready are both 1.
  - in_ready depends on registered full only. It has no combinational path from in_valid or the pop.
  - When full, a push is not accepted even if a pop happens that same cycle.
  - in_data is captured only on a push. in_valid while in_ready=0 is ignored; the CPU holds it.
- FIFO:
  - Circular buffer with wrap-around pointers; fifo_count is registered.
  - A simultaneous push and pop leaves the count unchanged and preserves data order.
- FSM states:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into shift register sh, clear the counter, and go to START. The pop and START entry happen on the same edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=sh[0] for CLKS_PER_BIT cycles, then shift sh right and increment the index. After bit 7 completes, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - IDLE costs one cycle between back-to-back frames, so the stop bit is effectively CLKS_PER_BIT+1 cycles. This is acceptable.
- Latency: a push into an empty FIFO with the FSM in IDLE drives uart_tx low exactly 2 cycles after the push edge.
  - Edge 1: the push is registered.
  - Edge 2: IDLE pops and moves to START.
- Outputs: uart_tx is driven from a register (glitch-free). busy = (state!=IDLE) || (fifo_count!=0).
- Width rules:
  - The baud counter is $clog2(CLKS_PER_BIT) bits and compares against CLKS_PER_BIT-1; there is no wrap beyond that.
  - The bit index is 3 bits.

Decomposition:
- Shared package ws_pkg (alongside the existing statetype/ASCII constants) holds:
  - txstate_t enum {TX_IDLE, TX_START, TX_DATA, TX_STOP};
  - constants UART_DATA_BITS=8, UART_IDLE=1'b1.
- One sub-module, ws_sync_fifo: parameterised width/depth with push/pop/full/empty/count, reset sync active-low. It is reusable later for the uart_rx input buffer.
- The FSM and baud counter stay in ws_uart_tx.

Test Plan:
1. CLKS_PER_BIT=4; push 0x41 once.
   - Line goes low 2 cycles after the push.
   - Sampled mid-bit, the sequence is 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 0x41, stop).
   - Frame lasts 40 cycles; busy=0 afterwards.
2. Push "Hi" (0x48, 0x69) on consecutive cycles.
   - Two frames decode to 0x48 then 0x69 with no gap beyond one idle cycle.
   - fifo_count reads 2 then 1 then 0.
3. Hold in_valid with 17 distinct bytes, FIFO_DEPTH=16, while TX is busy.
   - in_ready drops when the count reaches 16.
   - The 17th byte is accepted only after the next pop.
   - All 17 bytes are received in order with none duplicated or lost.
4. Push 0x00 and 0xFF back-to-back.
   - Receiver model decodes 0x00 and 0xFF.
   - For 0x00 the line is low for 9 bit-times; the stop bit is high.
5. Assert rst_n=0 in the middle of DATA bit 3 with 3 bytes queued.
   - Next cycle: uart_tx=1, busy=0, fifo_count=0.
   - No further frames after release until a new push.
6. Push and pop on the same edge with the FIFO at count 5.
   - Count stays 5.
   - Bytes are transmitted in push order; the wrap of the pointers is exercised over 40 total bytes.

Source files
------------

// File: rtl/ws_pkg.sv
// Shared Whitespace CPU types: UART transmit FSM states and line constants.
package ws_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txstate_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

endpackage

// File: rtl/ws_uart_tx_if.sv
// CPU-to-transmitter character handshake; a push happens when valid and ready meet on an edge.
// The master holds valid and data until ready is seen; ready depends only on registered FIFO state.
interface ws_uart_tx_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ws_sync_fifo.sv
// Synchronous circular FIFO with show-ahead head output; registered count, full and empty.
// Push is ignored when full and pop is ignored when empty, even if the other side moves that edge.
module ws_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ws_uart_tx.sv
// 8N1 UART transmitter fed by a FIFO; line falls 2 cycles after a push into an idle, empty queue.
// The CPU stalls only on a full FIFO (in_ready = !full); bit timing never backpressures it.
module ws_uart_tx
    import ws_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ws_uart_tx_if.slave                 cpu,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         IDX_LAST = 3'(UART_DATA_BITS - 1);

    txstate_t                  state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      tx_q, tx_d;

    logic                      push, pop, full, empty;
    logic [7:0]                head;

    assign cpu.in_ready = ~full;
    assign push         = cpu.in_valid & ~full;

    ws_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (cpu.in_data),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    cnt_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = TX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level is decoded from the next state so the pin comes straight off a flop.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = sh_d[0];
            default:  tx_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= UART_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q != TX_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ws_uart_tx.sv
// Bench for ws_uart_tx: line-pattern table, hand timed corner sequences and a mid-bit receiver scoreboard.
module tb_ws_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    ws_uart_tx_if cpu ();

    ws_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (cpu),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] dat;
        logic [9:0] line;   // bit i = level at mid of bit-time i (start, d0..d7, stop)
    } vec_t;
    vec_t vecs[6];

    task automatic check_b(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    task automatic check_n(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers a byte until accepted; edges = clock edges spent including the accepting one.
    task automatic push_byte(input logic [7:0] b, output int edges);
        logic hs;
        edges = 0;
        cpu.in_valid = 1'b1;
        cpu.in_data  = b;
        do begin
            hs = cpu.in_ready;
            @(posedge clk);
            #1;
            edges++;
        end while (!hs && edges < 2000);
        cpu.in_valid = 1'b0;
        if (hs) begin
            exp_q.push_back(b);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: byte 0x%0h not accepted after %0d edges, required acceptance", b, edges);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            tick(1);
            n++;
        end
        check_b(name, busy, 1'b0);
        tick(3);
    endtask

    // Receiver model: find a falling edge, sample each bit-time near its middle.
    initial begin : rx_monitor
        logic       prev;
        logic       ab;
        logic       st;
        logic       sp;
        logic [7:0] b;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !uart_tx) begin
                ab = 1'b0;
                for (int k = 0; k < CPB / 2; k++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                end
                st = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < CPB; k++) begin
                        @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                    end
                    b[i] = uart_tx;
                end
                for (int k = 0; k < CPB; k++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                end
                sp = uart_tx;
                if (!ab) begin
                    check_b("rx_start_bit", st, 1'b0);
                    check_b("rx_stop_bit", sp, 1'b1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_extra_byte: got 0x%0h, required no frame", b);
                    end else begin
                        check_n("rx_byte", int'(b), int'(exp_q.pop_front()));
                    end
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int e;
        int n;
        logic [7:0] r;

        vecs[0] = '{8'h41, 10'h282};
        vecs[1] = '{8'h48, 10'h290};
        vecs[2] = '{8'h69, 10'h2D2};
        vecs[3] = '{8'h00, 10'h200};
        vecs[4] = '{8'hFF, 10'h3FE};
        vecs[5] = '{8'hA5, 10'h34A};

        cpu.in_valid = 1'b0;
        cpu.in_data  = 8'h00;
        rst_n        = 1'b0;
        tick(3);
        check_b("rst_uart_tx", uart_tx, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        check_n("rst_fifo_count", int'(fifo_count), 0);
        check_b("rst_in_ready", cpu.in_ready, 1'b1);
        rst_n = 1'b1;
        tick(2);

        // Single frames from idle: latency, mid-bit levels and exact frame length.
        foreach (vecs[vi]) begin
            push_byte(vecs[vi].dat, e);
            check_n($sformatf("v%0d_count_after_push", vi), int'(fifo_count), 1);
            check_b($sformatf("v%0d_line_still_idle", vi), uart_tx, 1'b1);
            tick(1);
            check_b($sformatf("v%0d_line_low_2nd_edge", vi), uart_tx, 1'b0);
            check_n($sformatf("v%0d_count_after_pop", vi), int'(fifo_count), 0);
            tick(CPB / 2);
            for (int i = 0; i < 10; i++) begin
                check_b($sformatf("v%0d_bit%0d", vi, i), uart_tx, vecs[vi].line[i]);
                if (i < 9) tick(CPB);
            end
            tick(1);
            check_b($sformatf("v%0d_busy_last_cycle", vi), busy, 1'b1);
            tick(1);
            check_b($sformatf("v%0d_busy_after_frame", vi), busy, 1'b0);
            check_b($sformatf("v%0d_line_after_frame", vi), uart_tx, 1'b1);
            tick(2);
        end

        // "Hi" queued behind a frame in flight: count 2 -> 1 -> 0, one idle cycle between frames.
        push_byte(8'h3E, e);
        tick(1);
        push_byte(8'h48, e);
        push_byte(8'h69, e);
        check_n("hi_count_2", int'(fifo_count), 2);
        tick(38);
        check_b("hi_idle_gap_line", uart_tx, 1'b1);
        check_n("hi_count_still_2", int'(fifo_count), 2);
        tick(1);
        check_b("hi_H_start", uart_tx, 1'b0);
        check_n("hi_count_1", int'(fifo_count), 1);
        tick(41);
        check_b("hi_i_start", uart_tx, 1'b0);
        check_n("hi_count_0", int'(fifo_count), 0);
        wait_idle("hi_drain");

        // Fill to full while busy; the 17th byte waits for the next pop.
        push_byte(8'h2A, e);
        tick(2);
        for (int k = 0; k < 16; k++) push_byte(8'(8'h80 + k), e);
        check_n("full_count_16", int'(fifo_count), 16);
        check_b("full_in_ready_low", cpu.in_ready, 1'b0);
        push_byte(8'h90, e);
        check_n("full_17th_wait_edges", e, 25);
        check_n("full_count_after_17th", int'(fifo_count), 16);
        wait_idle("full_drain");

        // 0x00 then 0xFF back-to-back: 9 bit-times low, then stop plus one idle cycle high.
        push_byte(8'h00, e);
        push_byte(8'hFF, e);
        n = 0;
        while (uart_tx == 1'b0 && n < 1000) begin
            n++;
            tick(1);
        end
        check_n("zero_low_run", n, 9 * CPB);
        n = 0;
        while (uart_tx == 1'b1 && n < 1000) begin
            n++;
            tick(1);
        end
        check_n("zero_stop_high_run", n, CPB + 1);
        wait_idle("zero_ff_drain");

        // Reset in the middle of data bit 3 with three bytes queued.
        push_byte(8'h11, e);
        push_byte(8'h22, e);
        push_byte(8'h33, e);
        push_byte(8'h44, e);
        tick(15);
        check_n("rst_mid_queued", int'(fifo_count), 3);
        rst_n = 1'b0;
        tick(1);
        check_b("rst_mid_uart_tx", uart_tx, 1'b1);
        check_b("rst_mid_busy", busy, 1'b0);
        check_n("rst_mid_count", int'(fifo_count), 0);
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (uart_tx == 1'b0) n++;
        end
        check_n("rst_no_resume_low_cycles", n, 0);
        check_b("rst_no_resume_busy", busy, 1'b0);

        // Push on the pop edge at count 5, then random traffic to wrap the pointers (40 bytes).
        push_byte(8'h50, e);
        tick(1);
        for (int k = 0; k < 5; k++) push_byte(8'($urandom()), e);
        check_n("pp_count_5", int'(fifo_count), 5);
        tick(35);
        push_byte(8'($urandom()), e);
        check_n("pp_push_immediate", e, 1);
        check_n("pp_count_stays_5", int'(fifo_count), 5);
        check_b("pp_frame_started", uart_tx, 1'b0);
        for (int k = 0; k < 33; k++) begin
            r = 8'($urandom());
            push_byte(r, e);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 20));
        end
        wait_idle("pp_drain");
        check_n("all_bytes_received", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
